hit_knockback_ctrl: RTL
=======================

# hit_knockback_ctrl

Combat-resolution stage feeding both fighter movement blocks. Each frame it decodes the two players' attack keys, runs one attack state machine per player, and detects hits from the fighters' horizontal separation. It produces the `XDist` and per-player knockback velocities that the movement blocks add to their X position. It also maintains both health bars and the KO flag for the HUD.

## Interface
- STARTUP_FRAMES, 4, frames from attack press to active hitbox
- ACTIVE_FRAMES, 3, frames the hitbox is live
- RECOVERY_FRAMES, 8, frames after active before next attack allowed
- REACH, 160, max XDist (pixels) at which an active attack connects
- DAMAGE, 10, health removed per hit
- MAX_HEALTH, 100, health after reset
- KB_FRAMES, 6, frames of knockback applied to a hit fighter
- KB_SPEED, 3, knockback magnitude, pixels/frame
- P1_ATK_KEY, 8'h09, P1 attack keycode
- P2_ATK_KEY, 8'h12, P2 attack keycode
- frame_clk  in  1  frame clock (one edge per video frame)
- Reset  in  1  asynchronous, active-high
- keycode_0..keycode_3  in  8 each  currently pressed USB keycodes
- P1X, P2X  in  10 each  fighter X positions (P1 left, P2 right)
- XDist  out  32 signed  P2X − P1X, combinational
- P1_Knockback, P2_Knockback  out  32 signed  per-frame X offset for each fighter
- P1_Health, P2_Health  out  8  unsigned health
- P1_Attacking, P2_Attacking  out  1  high while that player's FSM is in ACTIVE
- KO  out  1  high once either health reaches 0

## Operation
- Key pressed = any of keycode_0..3 equals the key. Per-player prev-press register; an attack triggers only on a press edge (not pressed last frame, pressed now). Held key never retriggers.
- FSM per player: IDLE → STARTUP → ACTIVE → RECOVERY → IDLE. A down-counter is loaded on entry with STARTUP_FRAMES, ACTIVE_FRAMES or RECOVERY_FRAMES respectively; the state advances on the edge where the counter is 1.
- IDLE → STARTUP on a press edge only when kb_cnt == 0 for that player and KO == 0; otherwise the press is dropped.
- hit_done flag: cleared on entering STARTUP, set on hit.
- Hit condition, evaluated on each edge: attacker in ACTIVE, hit_done == 0, XDist ≤ REACH.
- On hit:
  - Victim health −= DAMAGE, saturating at 0.
  - Victim kb_cnt ← KB_FRAMES (reload if already nonzero).
  - Attacker hit_done ← 1.
  - If the victim is in STARTUP, it goes to IDLE (counter-hit cancel). ACTIVE and RECOVERY are not interrupted.
- Simultaneous hits: both apply in the same edge (trade).
- kb_cnt decrements by 1 per frame while nonzero.
- Knockback output, combinational:
  - P1_Knockback = −KB_SPEED if P1 kb_cnt ≠ 0 and P1X > KB_SPEED, else 0.
  - P2_Knockback = +KB_SPEED if P2 kb_cnt ≠ 0 and P2X + 125 + KB_SPEED < 637, else 0.
  - The wall check suppresses output only; kb_cnt still counts down.
- KO latches high when either health is 0. While KO is high: no new attacks start, in-flight FSMs run to IDLE, knockback completes.
- Arithmetic: XDist is sign-extended 10-bit difference (may be negative if fighters cross). Health subtraction is done in 9 bits, then clamped.

## Timing
- All state updates on posedge frame_clk. Reset is asynchronous and dominates the clock.
- Reset values:
  - Health = MAX_HEALTH; kb_cnt = 0; hit_done = 0; FSMs IDLE; prev-press = 0; KO = 0.
  - Hence Knockback = 0 and Attacking = 0.
- Reset mid-attack or mid-knockback aborts immediately to these values.
- Latencies:
  - Press edge sampled at edge N → STARTUP after N.
  - ACTIVE after edge N+STARTUP_FRAMES, lasting ACTIVE_FRAMES frames.
  - Hit registered at the first ACTIVE edge meeting the condition.
  - Victim knockback nonzero for the following KB_FRAMES frames.
  - Health updated on the hit edge.

## Structure
- Package fighter_pkg:
  - atk_state_t enum {IDLE, STARTUP, ACTIVE, RECOVERY}
  - Key constants 8'h09, 8'h12
  - Bound_X_Max = 637, FIGHTER_WIDTH = 125
- Sub-module attack_fsm, instantiated twice. It holds the state, phase counter, hit_done and prev-press register. Inputs: press, block, cancel, hit. Outputs: state, active.
- The top level holds XDist, hit resolution, kb counters, health and KO.

## Test plan
- Reset, then P1 taps 8'h09 for 1 frame at XDist = 100 → P1_Attacking high on edges 5–7. P2_Health 100→90 at edge 5. P2_Knockback = +3 for 6 frames, then 0.
- P1 holds 8'h09 for 40 frames → exactly one attack and one hit (health 90, not lower).
- P1 attack at XDist = 200 → no hit: health stays 100, knockback stays 0.
- Both players press their attack key on the same edge at XDist = 120 → both health 90, P1_Knockback = −3 and P2_Knockback = +3 concurrently.
- P2X = 510 while P2 is knocked back → P2_Knockback = 0 (wall), kb_cnt still expires after 6 frames.
- Ten P1 hits → P2_Health = 0, KO = 1. An 11th press starts no attack.
- Assert Reset during P2 knockback → all outputs at reset values immediately.

Source files
------------

// File: rtl/fighter_pkg.sv
// Shared types, keycodes, arena geometry and arithmetic helpers for the
// fighter combat blocks.
package fighter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      STARTUP,
      ACTIVE,
      RECOVERY
   } atk_state_t;

   localparam logic [7:0] KEY_P1_ATTACK = 8'h09;
   localparam logic [7:0] KEY_P2_ATTACK = 8'h12;

   localparam int Bound_X_Max   = 637;
   localparam int FIGHTER_WIDTH = 125;

   // Health minus damage, computed one bit wider so an underflow clamps to 0.
   function automatic logic [7:0] sat_sub(input logic [7:0] health, input logic [7:0] damage);
      logic [8:0] diff;
      diff = {1'b0, health} - {1'b0, damage};
      return diff[8] ? 8'd0 : diff[7:0];
   endfunction

   // True when any of the four reported USB keycodes matches the key.
   function automatic logic key_down(input logic [7:0] k0, input logic [7:0] k1,
                                     input logic [7:0] k2, input logic [7:0] k3,
                                     input logic [7:0] key);
      return (k0 == key) || (k1 == key) || (k2 == key) || (k3 == key);
   endfunction

endpackage

// File: rtl/hit_knockback_ctrl_if.sv
// Bundle of keyboard/position inputs and combat outputs shared between the
// combat stage and the blocks around it.
interface hit_knockback_ctrl_if;
   logic        [7:0]  keycode_0;
   logic        [7:0]  keycode_1;
   logic        [7:0]  keycode_2;
   logic        [7:0]  keycode_3;
   logic        [9:0]  P1X;
   logic        [9:0]  P2X;
   logic signed [31:0] XDist;
   logic signed [31:0] P1_Knockback;
   logic signed [31:0] P2_Knockback;
   logic        [7:0]  P1_Health;
   logic        [7:0]  P2_Health;
   logic               P1_Attacking;
   logic               P2_Attacking;
   logic               KO;

   modport master (
      output keycode_0, keycode_1, keycode_2, keycode_3, P1X, P2X,
      input  XDist, P1_Knockback, P2_Knockback, P1_Health, P2_Health,
             P1_Attacking, P2_Attacking, KO
   );

   modport slave (
      input  keycode_0, keycode_1, keycode_2, keycode_3, P1X, P2X,
      output XDist, P1_Knockback, P2_Knockback, P1_Health, P2_Health,
             P1_Attacking, P2_Attacking, KO
   );
endinterface

// File: rtl/attack_fsm.sv
// One player's attack sequencer: IDLE -> STARTUP -> ACTIVE -> RECOVERY.
// 'active' means the hitbox is live and has not yet connected this swing.
module attack_fsm
   import fighter_pkg::*;
#(
   parameter int STARTUP_FRAMES  = 4,
   parameter int ACTIVE_FRAMES   = 3,
   parameter int RECOVERY_FRAMES = 8
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       press,
   input  logic       block,
   input  logic       cancel,
   input  logic       hit,
   output atk_state_t state,
   output logic       active
);

   atk_state_t state_next;
   logic [7:0] phase_cnt;
   logic [7:0] phase_cnt_next;
   logic       hit_done;
   logic       hit_done_next;
   logic       prev_press;
   logic       press_edge;

   assign press_edge = press && !prev_press;
   assign active     = (state == ACTIVE) && !hit_done;

   // State, phase counter, hit latch and key history advance once per frame.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         phase_cnt  <= 8'd0;
         hit_done   <= 1'b0;
         prev_press <= 1'b0;
      end else begin
         state      <= state_next;
         phase_cnt  <= phase_cnt_next;
         hit_done   <= hit_done_next;
         prev_press <= press;
      end
   end

   // Each phase reloads the down-counter on entry and moves on when it reads 1.
   always_comb begin
      state_next     = state;
      phase_cnt_next = phase_cnt;
      hit_done_next  = hit_done || hit;
      case (state)
         IDLE: begin
            if (press_edge && !block) begin
               state_next     = STARTUP;
               phase_cnt_next = 8'(STARTUP_FRAMES);
               hit_done_next  = 1'b0;
            end
         end
         STARTUP: begin
            if (cancel) begin
               state_next     = IDLE;
               phase_cnt_next = 8'd0;
            end else if (phase_cnt == 8'd1) begin
               state_next     = ACTIVE;
               phase_cnt_next = 8'(ACTIVE_FRAMES);
            end else begin
               phase_cnt_next = phase_cnt - 8'd1;
            end
         end
         ACTIVE: begin
            if (phase_cnt == 8'd1) begin
               state_next     = RECOVERY;
               phase_cnt_next = 8'(RECOVERY_FRAMES);
            end else begin
               phase_cnt_next = phase_cnt - 8'd1;
            end
         end
         RECOVERY: begin
            if (phase_cnt == 8'd1) begin
               state_next     = IDLE;
               phase_cnt_next = 8'd0;
            end else begin
               phase_cnt_next = phase_cnt - 8'd1;
            end
         end
         default: begin
            state_next     = IDLE;
            phase_cnt_next = 8'd0;
         end
      endcase
   end

endmodule

// File: rtl/hit_knockback_ctrl.sv
// Combat resolution: decodes attack keys, runs both attack sequencers,
// resolves hits from horizontal separation, and owns knockback timers,
// health bars and the KO latch.
module hit_knockback_ctrl
   import fighter_pkg::*;
#(
   parameter int         STARTUP_FRAMES  = 4,
   parameter int         ACTIVE_FRAMES   = 3,
   parameter int         RECOVERY_FRAMES = 8,
   parameter int         REACH           = 160,
   parameter int         DAMAGE          = 10,
   parameter int         MAX_HEALTH      = 100,
   parameter int         KB_FRAMES       = 6,
   parameter int         KB_SPEED        = 3,
   parameter logic [7:0] P1_ATK_KEY      = KEY_P1_ATTACK,
   parameter logic [7:0] P2_ATK_KEY      = KEY_P2_ATTACK
) (
   input logic                 frame_clk,
   input logic                 Reset,
   hit_knockback_ctrl_if.slave bus
);

   localparam logic signed [31:0] KB_LEFT  = -KB_SPEED;
   localparam logic signed [31:0] KB_RIGHT = KB_SPEED;

   atk_state_t p1_state;
   atk_state_t p2_state;
   logic       p1_active;
   logic       p2_active;
   logic       p1_pressed;
   logic       p2_pressed;
   logic       p1_hit;
   logic       p2_hit;
   logic       in_reach;
   logic [9:0] x_diff;
   logic [31:0] p2_far_edge;
   logic [7:0] p1_kb;
   logic [7:0] p2_kb;
   logic [7:0] p1_health;
   logic [7:0] p2_health;
   logic [7:0] p1_health_next;
   logic [7:0] p2_health_next;
   logic       ko;

   assign x_diff    = bus.P2X - bus.P1X;
   assign bus.XDist = {{22{x_diff[9]}}, x_diff};
   assign in_reach  = (bus.XDist <= REACH);

   assign p1_pressed = key_down(bus.keycode_0, bus.keycode_1, bus.keycode_2, bus.keycode_3, P1_ATK_KEY);
   assign p2_pressed = key_down(bus.keycode_0, bus.keycode_1, bus.keycode_2, bus.keycode_3, P2_ATK_KEY);

   assign p1_hit = p1_active && in_reach;
   assign p2_hit = p2_active && in_reach;

   attack_fsm #(
      .STARTUP_FRAMES (STARTUP_FRAMES),
      .ACTIVE_FRAMES  (ACTIVE_FRAMES),
      .RECOVERY_FRAMES(RECOVERY_FRAMES)
   ) u_p1_fsm (
      .frame_clk(frame_clk),
      .Reset    (Reset),
      .press    (p1_pressed),
      .block    ((p1_kb != 8'd0) || ko),
      .cancel   (p2_hit),
      .hit      (p1_hit),
      .state    (p1_state),
      .active   (p1_active)
   );

   attack_fsm #(
      .STARTUP_FRAMES (STARTUP_FRAMES),
      .ACTIVE_FRAMES  (ACTIVE_FRAMES),
      .RECOVERY_FRAMES(RECOVERY_FRAMES)
   ) u_p2_fsm (
      .frame_clk(frame_clk),
      .Reset    (Reset),
      .press    (p2_pressed),
      .block    ((p2_kb != 8'd0) || ko),
      .cancel   (p1_hit),
      .hit      (p2_hit),
      .state    (p2_state),
      .active   (p2_active)
   );

   // Health after this frame's hits; a victim is hit by the other player's swing.
   always_comb begin
      p1_health_next = p1_health;
      p2_health_next = p2_health;
      if (p2_hit) p1_health_next = sat_sub(p1_health, 8'(DAMAGE));
      if (p1_hit) p2_health_next = sat_sub(p2_health, 8'(DAMAGE));
   end

   // Health, knockback timers and the KO latch; a fresh hit reloads the timer.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         p1_health <= 8'(MAX_HEALTH);
         p2_health <= 8'(MAX_HEALTH);
         p1_kb     <= 8'd0;
         p2_kb     <= 8'd0;
         ko        <= 1'b0;
      end else begin
         p1_health <= p1_health_next;
         p2_health <= p2_health_next;
         if (p2_hit)              p1_kb <= 8'(KB_FRAMES);
         else if (p1_kb != 8'd0)  p1_kb <= p1_kb - 8'd1;
         if (p1_hit)              p2_kb <= 8'(KB_FRAMES);
         else if (p2_kb != 8'd0)  p2_kb <= p2_kb - 8'd1;
         ko <= ko || (p1_health_next == 8'd0) || (p2_health_next == 8'd0);
      end
   end

   assign p2_far_edge = {22'd0, bus.P2X} + 32'(FIGHTER_WIDTH + KB_SPEED);

   assign bus.P1_Knockback = ((p1_kb != 8'd0) && ({22'd0, bus.P1X} > 32'(KB_SPEED))) ? KB_LEFT : 32'sd0;
   assign bus.P2_Knockback = ((p2_kb != 8'd0) && (p2_far_edge < 32'(Bound_X_Max)))   ? KB_RIGHT : 32'sd0;

   assign bus.P1_Health    = p1_health;
   assign bus.P2_Health    = p2_health;
   assign bus.P1_Attacking = (p1_state == ACTIVE);
   assign bus.P2_Attacking = (p2_state == ACTIVE);
   assign bus.KO           = ko;

endmodule
